// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: session controller for serial pattern detection.
// A start command latches the pattern/length/limits, then bits are pulled
// over a valid/ready stream into a shift history. Overlapping matches are
// counted and the session ends on match count, window expiry or abort.
module pattern_scan_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [7:0]                   cfg_stop_cnt,
    input  logic [CNT_W-1:0]             cfg_window,
    input  logic                         in_valid,
    input  logic                         in_bit,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         hit,
    output logic [7:0]                   match_cnt,
    output logic [CNT_W-1:0]             last_pos,
    output logic [1:0]                   status
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Mask selecting the low 'len' bits of the history.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (LEN_W'(k) < len) begin
                m[k] = 1'b1;
            end else begin
                m[k] = 1'b0;
            end
        end
        return m;
    endfunction

    state_t               r_state;
    logic [MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]     r_len;
    logic [7:0]           r_stop;
    logic [CNT_W-1:0]     r_win;
    // Only the previous MAX_LEN-1 bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0]   r_hist;
    logic [LEN_W-1:0]     r_fill;
    logic [CNT_W-1:0]     r_bit_idx;
    logic [7:0]           r_match_cnt;
    logic [CNT_W-1:0]     r_last_pos;
    logic [1:0]           r_status;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_hit;

    logic                 w_accept;
    logic [MAX_LEN-1:0]   w_hist_new;
    logic [LEN_W-1:0]     w_fill_new;
    logic [CNT_W-1:0]     w_bits_new;
    logic                 w_match;
    logic [7:0]           w_cnt_new;
    logic                 w_stop;
    logic                 w_win;

    // Abort blocks acceptance in the same cycle, so ready drops combinationally.
    assign in_ready  = (r_state == S_SCAN) && !abort;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hit       = r_hit;
    assign match_cnt = r_match_cnt;
    assign last_pos  = r_last_pos;
    assign status    = r_status;

    // Next history/fill and the match / end-of-session decisions for the bit on the bus.
    always_comb begin
        w_accept   = (r_state == S_SCAN) && in_valid && !abort;
        w_hist_new = {r_hist, in_bit};
        if (r_fill < LEN_MAX) begin
            w_fill_new = r_fill + LEN_W'(1);
        end else begin
            w_fill_new = r_fill;
        end
        w_bits_new = r_bit_idx + CNT_W'(1);
        w_match    = w_accept && (r_len != '0) && (w_fill_new >= r_len) &&
                     (((w_hist_new ^ r_pat) & len_mask(r_len)) == '0);
        if (r_match_cnt == 8'hFF) begin
            w_cnt_new = r_match_cnt;
        end else begin
            w_cnt_new = r_match_cnt + 8'd1;
        end
        w_stop = w_match && (r_stop != 8'd0) && (w_cnt_new == r_stop);
        w_win  = w_accept && (r_win != '0) && (w_bits_new == r_win);
    end

    // Session FSM with registered status/pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_stop      <= 8'd0;
            r_win       <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_bit_idx   <= '0;
            r_match_cnt <= 8'd0;
            r_last_pos  <= '0;
            r_status    <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat   <= cfg_pattern;
                        r_len   <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                        r_stop  <= cfg_stop_cnt;
                        r_win   <= cfg_window;
                        r_busy  <= 1'b1;
                        r_state <= S_ARM;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARM: begin
                    r_hist      <= '0;
                    r_fill      <= '0;
                    r_bit_idx   <= '0;
                    r_match_cnt <= 8'd0;
                    r_last_pos  <= '0;
                    if (abort) begin
                        r_status <= 2'b11;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_status <= 2'b00;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_status <= 2'b11;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (w_accept) begin
                        r_hist    <= w_hist_new[MAX_LEN-2:0];
                        r_fill    <= w_fill_new;
                        r_bit_idx <= w_bits_new;
                        if (w_match) begin
                            r_hit       <= 1'b1;
                            r_match_cnt <= w_cnt_new;
                            r_last_pos  <= r_bit_idx;
                        end else begin
                            r_hit <= 1'b0;
                        end
                        // Count limit takes priority when both limits land on the same bit.
                        if (w_stop) begin
                            r_status <= 2'b01;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_win) begin
                            r_status <= 2'b10;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: the session driver runs a
// list-of-bits reference model and queues expected hit/done events; a
// negedge monitor pops and compares whenever the DUT pulses hit or done.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [7:0]  cfg_stop_cnt;
    logic [15:0] cfg_window;
    logic        in_valid, in_bit;
    logic        in_ready, busy, done, hit;
    logic [7:0]  match_cnt;
    logic [15:0] last_pos;
    logic [1:0]  status;

    pattern_scan_ctrl #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_stop_cnt(cfg_stop_cnt), .cfg_window(cfg_window),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .busy(busy), .done(done), .hit(hit), .match_cnt(match_cnt),
        .last_pos(last_pos), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        int pos;
        int st;
    } ev_t;

    ev_t hit_q[$];
    ev_t done_q[$];
    ev_t me;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every hit/done pulse against the queued expectation.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (hit) begin
                if (hit_q.size() == 0) begin
                    chk("unexpected_hit", 32'd1, 32'd0);
                end else begin
                    me = hit_q.pop_front();
                    chk("hit_cycle", cyc, me.cyc);
                    chk("hit_match_cnt", match_cnt, me.cnt);
                    chk("hit_last_pos", last_pos, me.pos);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    me = done_q.pop_front();
                    chk("done_cycle", cyc, me.cyc);
                    chk("done_status", status, me.st);
                    chk("done_match_cnt", match_cnt, me.cnt);
                    chk("done_last_pos", last_pos, me.pos);
                    chk("done_busy", busy, 32'd0);
                    chk("done_in_ready", in_ready, 32'd0);
                end
            end
        end
    end

    // One session: the model keeps the accepted bits as a list and matches
    // the newest len bits (newest = pattern bit 0) against the pattern.
    task automatic run_session(input logic [7:0] pat, input int len, input int stop,
                               input int win, input logic [31:0] bits, input int nbits,
                               input bit rnd, input int abort_at, input int max_cyc,
                               input int exp_cnt, input int exp_pos, input int exp_st);
        bit hist[$];
        int cnt = 0, pos = 0, idx = 0, st = 0, lenc;
        bit ended = 1'b0, m, v, b, ab;
        ev_t e;
        lenc = (len > 8) ? 8 : len;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 32'd0);
        start = 1'b1; cfg_pattern = pat; cfg_len = len[3:0];
        cfg_stop_cnt = stop[7:0]; cfg_window = win[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("arm_busy", busy, 32'd1);
        chk("arm_in_ready", in_ready, 32'd0);
        @(posedge clk); #1;
        for (int c = 0; !ended; c++) begin
            v  = rnd ? ($urandom_range(3) != 0) : (idx < nbits);
            b  = rnd ? 1'($urandom_range(1)) : bits[idx];
            ab = (c == abort_at) || (c >= max_cyc);
            if (rnd) begin
                start        = ($urandom_range(4) == 0);
                cfg_pattern  = 8'($urandom);
                cfg_len      = 4'($urandom);
                cfg_stop_cnt = 8'($urandom);
                cfg_window   = 16'($urandom);
            end
            in_valid = v; in_bit = b; abort = ab;
            #1;
            chk("scan_in_ready", in_ready, {31'd0, !ab});
            chk("scan_busy", busy, 32'd1);
            if (ab) begin
                e = '{cyc + 1, cnt, pos, 3};
                done_q.push_back(e);
                ended = 1'b1;
            end else if (v) begin
                hist.push_back(b);
                m = (lenc != 0) && (hist.size() >= lenc);
                for (int k = 0; k < lenc; k++) begin
                    if (m && hist[hist.size() - 1 - k] != pat[k]) m = 1'b0;
                end
                if (m) begin
                    cnt = (cnt < 255) ? cnt + 1 : 255;
                    pos = idx;
                    e = '{cyc + 1, cnt, pos, 0};
                    hit_q.push_back(e);
                end
                idx++;
                if (m && stop != 0 && cnt == stop) st = 1;
                else if (win != 0 && idx == win) st = 2;
                if (st != 0) begin
                    e = '{cyc + 1, cnt, pos, st};
                    done_q.push_back(e);
                    ended = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        if (st == 0) st = 3;
        // DONE cycle: start/abort here must be ignored.
        start = 1'b1; abort = 1'b1; in_valid = 1'b0;
        cfg_pattern = 8'($urandom); cfg_len = 4'($urandom);
        chk("done_cycle_in_ready", in_ready, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("idle_busy", busy, 32'd0);
        chk("idle_in_ready_after", in_ready, 32'd0);
        chk("final_match_cnt", match_cnt, cnt);
        chk("final_last_pos", last_pos, pos);
        chk("final_status", status, st);
        chk("hit_queue_drained", hit_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        if (exp_cnt >= 0) chk("directed_cnt", match_cnt, exp_cnt);
        if (exp_pos >= 0) chk("directed_pos", last_pos, exp_pos);
        if (exp_st >= 0)  chk("directed_status", status, exp_st);
        hit_q.delete();
        done_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = 8'd0; cfg_len = 4'd0; cfg_stop_cnt = 8'd0; cfg_window = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_hit", hit, 32'd0);
        chk("rst_match_cnt", match_cnt, 32'd0);
        chk("rst_last_pos", last_pos, 32'd0);
        chk("rst_status", status, 32'd0);
        chk("rst_in_ready", in_ready, 32'd0);
        reset = 1'b0;
        // Directed: single match stop, overlapping window, count beats window,
        // abort mid-scan, length clamp.
        run_session(8'b1011, 4, 1, 0,  32'h0000000D, 4, 1'b0, -1, 60, 1, 3, 1);
        run_session(8'b101,  3, 0, 8,  32'h00000055, 8, 1'b0, -1, 60, 3, 6, 2);
        run_session(8'b11,   2, 2, 5,  32'h0000001B, 5, 1'b0, -1, 60, 2, 4, 1);
        run_session(8'b1,    1, 0, 0,  32'h0000000F, 4, 1'b0,  2, 60, 2, 1, 3);
        run_session(8'hFF,  12, 2, 0,  32'h000001FF, 9, 1'b0, -1, 60, 2, 8, 1);
        run_session(8'h00,   0, 0, 10, 32'h00000000, 10, 1'b0, -1, 60, 0, 0, 2);
        // Abort during ARM.
        @(posedge clk); #1;
        start = 1'b1; cfg_pattern = 8'd1; cfg_len = 4'd1; cfg_stop_cnt = 8'd0; cfg_window = 16'd0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        done_q.push_back('{cyc + 1, 0, 0, 3});
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;
        chk("arm_abort_status", status, 32'd3);
        chk("arm_abort_drained", done_q.size(), 32'd0);
        done_q.delete();
        // Randomised sessions with mid-session start/cfg noise.
        for (int s = 0; s < 25; s++) begin
            int len, stp, wn, ab;
            len = ($urandom_range(3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
            stp = $urandom_range(0, 4);
            wn  = $urandom_range(0, 24);
            ab  = ($urandom_range(3) == 0) ? $urandom_range(0, 20) : -1;
            run_session(8'($urandom), len, stp, wn, 32'd0, 0, 1'b1, ab, 60, -1, -1, -1);
        end
        // Asynchronous reset mid-scan.
        @(posedge clk); #1;
        mon_en = 1'b0;
        start = 1'b1; cfg_pattern = 8'd1; cfg_len = 4'd1; cfg_stop_cnt = 8'd0; cfg_window = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_match_cnt", match_cnt, 32'd0);
        chk("mid_rst_last_pos", last_pos, 32'd0);
        chk("mid_rst_status", status, 32'd0);
        chk("mid_rst_hit", hit, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        hit_q.delete();
        done_q.delete();
        run_session(8'hAA, 0, 0, 12, 32'd0, 0, 1'b1, -1, 60, 0, 0, 2);
        run_session(8'b110, 3, 3, 0, 32'd0, 0, 1'b1, -1, 60, -1, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
